onewire_slave_phy: RTL and testbench

1-Wire responder-side physical layer: watches the shared DQ line, detects master reset pulses and answers with a presence pulse, and decodes master time slots into bytes. It receives bytes in write slots and returns a loaded byte in read slots. It sits between the DQ open-drain pad and the slave's command/ROM logic, and is the bus counterpart of the master `control_logic`/transaction FSM. All timing is derived from a cycles-per-microsecond parameter.

---
 rtl/onewire_slave_phy_if.sv | 37 +++
 rtl/onewire_slave_phy.sv | 197 +++++++++++++++++++
 tb/tb_onewire_slave_phy.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_slave_phy_if.sv
// Bundles the signals between the 1-Wire responder PHY, its DQ pad and its command logic.
// Latency: none; this is wiring only.
// Backpressure: tx_ready/tx_load is the only handshake; rx_valid, tx_done and bus_reset are unthrottled pulses.
// Ports:
//   dq_in     pad -> phy   raw DQ level (asynchronous)
//   dq_pull   phy -> pad   1 = pull DQ low through the open-drain pad
//   tx_data   host -> phy  byte returned in read slots, LSB first
//   tx_load   host -> phy  one-cycle strobe, accepted while tx_ready=1
//   tx_ready  phy -> host  1 = no byte pending
//   tx_done   phy -> host  one-cycle pulse after the 8th read slot
//   rx_data   phy -> host  last received byte
//   rx_valid  phy -> host  one-cycle pulse when rx_data updates
//   bus_reset phy -> host  one-cycle pulse on master reset pulse detection
`timescale 1ns/1ps
interface onewire_slave_phy_if;
    logic       dq_in;
    logic       dq_pull;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bus_reset;

    // PHY side
    modport slave (
        input  dq_in, tx_data, tx_load,
        output dq_pull, tx_ready, tx_done, rx_data, rx_valid, bus_reset
    );

    // Pad/host side
    modport master (
        output dq_in, tx_data, tx_load,
        input  dq_pull, tx_ready, tx_done, rx_data, rx_valid, bus_reset
    );
endinterface

// File: rtl/onewire_slave_phy.sv
// 1-Wire responder PHY: reset/presence handling and time-slot bit/byte transfer on DQ.
// Latency: pad-to-dq_s 2 cycles; edge acted on the first cycle dq_s reads 0; outputs registered.
// Backpressure: tx_load ignored while tx_ready=0; rx_valid/tx_done/bus_reset are pulses with no stall.
// Ports: clk, rst (async active-high), bus (onewire_slave_phy_if.slave; see interface file).
`timescale 1ns/1ps
module onewire_slave_phy #(
    parameter int CLKS_PER_US = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    onewire_slave_phy_if.slave    bus
);

    localparam int SAMPLE_N = 30  * CLKS_PER_US;
    localparam int SLOT_N   = 60  * CLKS_PER_US;
    localparam int RST_N    = 480 * CLKS_PER_US;
    localparam int PDLY_N   = 30  * CLKS_PER_US;
    localparam int PDRV_N   = 120 * CLKS_PER_US;
    localparam int CW       = $clog2(RST_N + 1);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_N - 1);
    localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT_N - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_N - 1);
    localparam logic [CW-1:0] PDLY_LAST   = CW'(PDLY_N - 1);
    localparam logic [CW-1:0] PDRV_LAST   = CW'(PDRV_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLOT,
        S_LOWWAIT,
        S_RSTHOLD,
        S_PDLY,
        S_PDRV
    } state_t;

    state_t        state;
    logic          sync1;
    logic          dq_s;
    logic          dq_d;
    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] low_cnt;
    logic [2:0]    bit_cnt;
    logic          rd_mode;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;

    logic          pull_q;
    logic          ready_q;
    logic          done_q;
    logic [7:0]    rxd_q;
    logic          rxv_q;
    logic          brst_q;

    logic          fall;
    logic          watching;

    assign fall     = dq_d & ~dq_s;
    // Reset pulses are only recognised while not already handling one.
    assign watching = (state == S_IDLE) || (state == S_SLOT) || (state == S_LOWWAIT);

    assign bus.dq_pull   = pull_q;
    assign bus.tx_ready  = ready_q;
    assign bus.tx_done   = done_q;
    assign bus.rx_data   = rxd_q;
    assign bus.rx_valid  = rxv_q;
    assign bus.bus_reset = brst_q;

    // Synchroniser presets high so reset looks like an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            dq_s  <= 1'b1;
            dq_d  <= 1'b1;
        end else begin
            sync1 <= bus.dq_in;
            dq_s  <= sync1;
            dq_d  <= dq_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            slot_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= 3'd0;
            rd_mode  <= 1'b0;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            pull_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            rxd_q    <= 8'h00;
            rxv_q    <= 1'b0;
            brst_q   <= 1'b0;
        end else begin
            rxv_q  <= 1'b0;
            done_q <= 1'b0;
            brst_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state    <= S_SLOT;
                        slot_cnt <= '0;
                        // Slot direction is frozen at the edge so a mid-slot
                        // tx_load cannot flip an in-flight slot.
                        rd_mode  <= ~ready_q;
                        if (!ready_q && !tx_sh[0]) begin
                            pull_q <= 1'b1;
                        end
                    end
                end
                S_SLOT: begin
                    slot_cnt <= slot_cnt + 1'b1;
                    if (slot_cnt == SAMPLE_LAST) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (rd_mode) begin
                            pull_q <= 1'b0;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            if (bit_cnt == 3'd7) begin
                                ready_q <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            rx_sh <= {dq_s, rx_sh[7:1]};
                            if (bit_cnt == 3'd7) begin
                                rxd_q <= {dq_s, rx_sh[7:1]};
                                rxv_q <= 1'b1;
                            end
                        end
                    end
                    if (slot_cnt == SLOT_LAST) begin
                        state <= dq_s ? S_IDLE : S_LOWWAIT;
                    end
                end
                S_LOWWAIT: begin
                    if (dq_s) begin
                        state <= S_IDLE;
                    end
                end
                S_RSTHOLD: begin
                    // Start at 1 so the presence drive begins exactly PDLY
                    // cycles after dq_s returns high.
                    if (dq_s) begin
                        state    <= S_PDLY;
                        slot_cnt <= CW'(1);
                    end
                end
                S_PDLY: begin
                    if (slot_cnt == PDLY_LAST) begin
                        state    <= S_PDRV;
                        slot_cnt <= '0;
                        pull_q   <= 1'b1;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                S_PDRV: begin
                    if (slot_cnt == PDRV_LAST) begin
                        state  <= S_IDLE;
                        pull_q <= 1'b0;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (bus.tx_load && ready_q) begin
                tx_sh   <= bus.tx_data;
                bit_cnt <= 3'd0;
                ready_q <= 1'b0;
            end

            // Reset detection is last so it overrides slot and load updates.
            if (watching && !dq_s) begin
                if (low_cnt == RST_LAST) begin
                    low_cnt <= '0;
                    brst_q  <= 1'b1;
                    pull_q  <= 1'b0;
                    bit_cnt <= 3'd0;
                    rx_sh   <= 8'h00;
                    ready_q <= 1'b1;
                    state   <= S_RSTHOLD;
                end else begin
                    low_cnt <= low_cnt + 1'b1;
                end
            end else begin
                low_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave_phy.sv
// Directed bench for onewire_slave_phy: master-side slot/reset driver with a wired-AND DQ model.
// Latency: all timing figures are measured in cycles from master pad events.
// Backpressure: none; the bench drives tx_load only when it expects acceptance or rejection.
`timescale 1ns/1ps
module tb_onewire_slave_phy;

    logic clk;
    logic rst;
    logic mst_low;

    onewire_slave_phy_if bus();

    // Open-drain wire: low if either side pulls.
    assign bus.dq_in = ~(mst_low | bus.dq_pull);

    onewire_slave_phy #(.CLKS_PER_US(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling clock edge.
    int         ncyc = 0;
    int         rxv_n = 0;
    int         br_n = 0;
    int         td_n = 0;
    int         pull_n = 0;
    logic [7:0] rxv_dat = 8'h00;
    int         br_cyc = 0;
    int         mfall_cyc = 0;
    int         mrise_cyc = 0;
    int         prise_cyc = 0;
    int         plen_last = 0;
    int         plen_run = 0;
    logic       prev_pull = 1'b0;
    logic       prev_mlow = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (bus.rx_valid) begin
            rxv_n++;
            rxv_dat = bus.rx_data;
        end
        if (bus.bus_reset) begin
            br_n++;
            br_cyc = ncyc;
        end
        if (bus.tx_done) td_n++;
        if (mst_low && !prev_mlow) mfall_cyc = ncyc;
        if (!mst_low && prev_mlow) mrise_cyc = ncyc;
        if (bus.dq_pull) begin
            if (!prev_pull) begin
                prise_cyc = ncyc;
                pull_n++;
                plen_run = 0;
            end
            plen_run++;
        end else if (prev_pull) begin
            plen_last = plen_run;
        end
        prev_pull = bus.dq_pull;
        prev_mlow = mst_low;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 70 us slot: write-1 is 6 us low, write-0 is 60 us low.
    task automatic write_bit(input logic b);
        mst_low = 1'b1;
        tick(b ? 60 : 600);
        mst_low = 1'b0;
        tick(b ? 640 : 100);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    // Read slots with 6 us master low; a 0 bit must show one 300-cycle pull.
    task automatic read_byte(input logic [7:0] v, input string tag);
        int p0;
        for (int i = 0; i < 8; i++) begin
            p0 = pull_n;
            mst_low = 1'b1;
            tick(60);
            mst_low = 1'b0;
            tick(640);
            check($sformatf("%s_pull_slot%0d", tag, i), pull_n - p0, v[i] ? 0 : 1);
            if (!v[i]) check($sformatf("%s_len_slot%0d", tag, i), plen_last, 300);
        end
    endtask

    task automatic load(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        tick(1);
    endtask

    task automatic low_pulse(input int n);
        mst_low = 1'b1;
        tick(n);
        mst_low = 1'b0;
    endtask

    int rx0, br0, td0, p0;

    initial begin
        rst         = 1'b1;
        mst_low     = 1'b0;
        bus.tx_load = 1'b0;
        bus.tx_data = 8'h00;
        tick(3);
        check("rst_dq_pull",   bus.dq_pull,   0);
        check("rst_tx_ready",  bus.tx_ready,  1);
        check("rst_rx_data",   bus.rx_data,   8'h00);
        check("rst_rx_valid",  bus.rx_valid,  0);
        check("rst_bus_reset", bus.bus_reset, 0);
        check("rst_tx_done",   bus.tx_done,   0);
        rst = 1'b0;
        tick(5);

        // Write byte A5.
        rx0 = rxv_n; p0 = pull_n;
        write_byte(8'hA5);
        check("wr_a5_valid_cnt", rxv_n - rx0, 1);
        check("wr_a5_valid_dat", rxv_dat, 8'hA5);
        check("wr_a5_rx_data",   bus.rx_data, 8'hA5);
        check("wr_a5_no_pull",   pull_n - p0, 0);

        // Reset and presence.
        br0 = br_n;
        low_pulse(5000);
        tick(1600);
        check("rp_bus_reset_cnt", br_n - br0, 1);
        check("rp_reset_delay",   br_cyc - mfall_cyc, 4802);
        check("rp_presence_dly",  prise_cyc - mrise_cyc, 302);
        check("rp_presence_len",  plen_last, 1200);

        // Read byte 3C.
        td0 = td_n;
        load(8'h3C);
        check("rd_3c_ready_low", bus.tx_ready, 0);
        read_byte(8'h3C, "rd_3c");
        check("rd_3c_done_cnt", td_n - td0, 1);
        check("rd_3c_ready",    bus.tx_ready, 1);

        // Reset mid-byte with a pending tx byte.
        rx0 = rxv_n; td0 = td_n; br0 = br_n;
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        load(8'h55);
        low_pulse(5000);
        tick(1600);
        check("mid_bus_reset",   br_n - br0, 1);
        check("mid_tx_ready",    bus.tx_ready, 1);
        check("mid_no_tx_done",  td_n - td0, 0);
        check("mid_no_rx_valid", rxv_n - rx0, 0);
        write_byte(8'h0F);
        check("mid_valid_cnt", rxv_n - rx0, 1);
        check("mid_rx_data",   bus.rx_data, 8'h0F);

        // Threshold: 4799 cycles is not a reset, 4800 is.
        br0 = br_n; p0 = pull_n;
        low_pulse(4799);
        tick(1600);
        check("thr_4799_no_reset",    br_n - br0, 0);
        check("thr_4799_no_presence", pull_n - p0, 0);
        low_pulse(4800);
        tick(1600);
        check("thr_4800_reset",   br_n - br0, 1);
        check("thr_4800_delay",   br_cyc - mfall_cyc, 4802);
        check("thr_4800_presence", pull_n - p0, 1);

        // tx_load while busy is ignored.
        td0 = td_n;
        load(8'h96);
        load(8'hFF);
        read_byte(8'h96, "rej");
        check("rej_done_cnt", td_n - td0, 1);

        // Async reset during presence drive.
        low_pulse(5000);
        for (int i = 0; i < 400 && !bus.dq_pull; i++) tick(1);
        check("ar_in_presence", bus.dq_pull, 1);
        tick(100);
        #2;
        rst = 1'b1;
        #1;
        check("ar_dq_pull",   bus.dq_pull,   0);
        check("ar_tx_ready",  bus.tx_ready,  1);
        check("ar_rx_data",   bus.rx_data,   8'h00);
        check("ar_rx_valid",  bus.rx_valid,  0);
        check("ar_bus_reset", bus.bus_reset, 0);
        check("ar_tx_done",   bus.tx_done,   0);
        tick(2);
        rst = 1'b0;
        p0 = pull_n;
        tick(1500);
        check("ar_no_pull_after", pull_n - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
